control_loop_sequencer: RTL and testbench
=========================================

Name: control_loop_sequencer

Overview:
Sample-rate scheduler for the closed control loop: ADC capture, y register load, I_PD compute, I_PD register load for Offset_OUT/PWM.
- Generates the loop sample tick.
- Starts each ADC conversion and waits for capture complete.
- Sequences the register enables and the controller start/done handshake.
- Watchdogs every stage and counts sample overruns.

Parameters:
PERIOD, 500000, clock cycles between sample ticks (loop rate); minimum 8.
ADC_TIMEOUT, 450000, maximum cycles in ADC_WAIT before fault.
CALC_TIMEOUT, 1024, maximum cycles in CALC before fault.
CNT_W, 20, width of the period and watchdog counters; must hold PERIOD-1 and both timeouts.

Ports:
CLK  in  1  system clock; all logic is on the rising edge.
Reset  in  1  asynchronous, active-low reset.
Enable  in  1  loop run request.
fault_clr  in  1  synchronous clear of fault.
adc_start  out  1  one-cycle pulse that starts an ADC conversion.
adc_done  in  1  one-cycle pulse: 16-bit capture valid.
y_load  out  1  one-cycle enable for the y register.
calc_start  out  1  one-cycle pulse that starts I_PD.
calc_done  in  1  I_PD result ready (Listo).
u_load  out  1  one-cycle enable for the I_PD output register.
busy  out  1  high when state is not IDLE.
fault  out  1  sticky watchdog fault flag.
overrun_cnt  out  8  count of dropped ticks; saturates at 255.
state  out  3  current state encoding, for debug.

Behaviour:
- Reset=0: all outputs 0, state=IDLE, period counter 0, watchdog 0. Reset mid-sequence aborts immediately; no load pulse is emitted.
- All outputs are registered.
- State encoding: IDLE=0, ADC_WAIT=1, LOAD=2, CALC=3, UPDATE=4. Encodings 5-7 go to IDLE.
- Period counter:
  - Counts 0..PERIOD-1 while Enable=1 and wraps to 0.
  - tick is an internal one-cycle signal, asserted when the count equals PERIOD-1.
  - Enable=0 holds the counter at 0, so no ticks occur.
  - An in-flight sequence still completes normally, then the FSM stays in IDLE.
- IDLE:
  - tick -> ADC_WAIT, with adc_start=1 in the first ADC_WAIT cycle (tick at cycle T gives adc_start at T+1).
  - Watchdog cleared on every state entry.
- ADC_WAIT:
  - adc_done=1 -> LOAD.
  - Watchdog reaches ADC_TIMEOUT-1 without adc_done -> set fault, go to IDLE, no y_load.
  - adc_done in the same cycle as the timeout: adc_done wins.
- LOAD:
  - y_load=1 for exactly this one cycle, then -> CALC.
  - adc_done at cycle A gives y_load at A+1.
- CALC:
  - calc_start=1 in the first CALC cycle only (A+2).
  - calc_done is ignored in that first cycle and sampled from the second cycle on.
  - calc_done -> UPDATE.
  - Watchdog reaches CALC_TIMEOUT-1 -> set fault, go to IDLE, no u_load.
- UPDATE:
  - u_load=1 for one cycle (calc_done at C gives u_load at C+1), then IDLE at C+2.
- Overrun:
  - A tick while state is not IDLE is dropped (no queued start).
  - overrun_cnt increments, saturating at 255.
  - A tick coincident with the UPDATE->IDLE transition also counts as an overrun.
- fault_clr=1 clears fault next cycle. A new fault in the same cycle as fault_clr leaves fault=1. overrun_cnt is cleared only by Reset.
- busy = (state != IDLE).

Optional Feature:
LOOP_SEQ_HOLD_ON_FAULT_EN
- Defined: while fault=1, ticks do not start a sequence and are not counted as overruns. The loop resumes on the first tick after fault_clr.
- Undefined: fault is purely a status flag, and sequencing continues on every tick.

Test Plan:
All scenarios use PERIOD=20, ADC_TIMEOUT=10, CALC_TIMEOUT=6.
1. Reset release, Enable=1; adc_done 3 cycles after adc_start; calc_done 2 cycles after calc_start -> adc_start at cycle 20; y_load at adc_done+1, calc_start at +2, u_load at calc_done+1; busy low before the next tick; overrun_cnt=0.
2. adc_done never arrives -> fault=1 at the 10th ADC_WAIT cycle; no y_load/u_load; next tick at count 19 restarts (macro undefined) or stays IDLE (macro defined) until fault_clr.
3. calc_done held high constantly -> ignored in the calc_start cycle; u_load exactly 2 cycles after calc_start; one u_load per period.
4. adc_done delayed 25 cycles (ADC_TIMEOUT raised to 40) -> one tick dropped; overrun_cnt=1; 300 such periods -> overrun_cnt saturates at 255.
5. Reset driven low during CALC -> all outputs 0 immediately; no u_load after Reset returns high; first adc_start at cycle 20 after release.
6. Enable dropped during ADC_WAIT -> sequence completes through u_load, then IDLE with no further adc_start; Enable re-raised -> adc_start 20 cycles later.

Source files
------------

// File: rtl/control_loop_sequencer.sv
// Sample-rate scheduler: tick -> ADC capture -> y load -> I_PD calc -> u load.
// Define LOOP_SEQ_HOLD_ON_FAULT_EN to suspend sequencing while fault is set.
module control_loop_sequencer #(
  parameter int PERIOD       = 500000,
  parameter int ADC_TIMEOUT  = 450000,
  parameter int CALC_TIMEOUT = 1024,
  parameter int CNT_W        = 20
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       fault_clr,
  output logic       adc_start,
  input  logic       adc_done,
  output logic       y_load,
  output logic       calc_start,
  input  logic       calc_done,
  output logic       u_load,
  output logic       busy,
  output logic       fault,
  output logic [7:0] overrun_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADC_WAIT = 3'd1,
    LOAD     = 3'd2,
    CALC     = 3'd3,
    UPDATE   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] PER_MAX  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] ADC_MAX  = CNT_W'(ADC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CALC_MAX = CNT_W'(CALC_TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wd_q;
  logic [7:0]       ovr_q, ovr_d;
  logic             adc_start_q;
  logic             y_load_q;
  logic             calc_start_q;
  logic             u_load_q;
  logic             busy_q;
  logic             fault_q;
  logic             tick;
  logic             run_ok;

`ifdef LOOP_SEQ_HOLD_ON_FAULT_EN
  assign run_ok = ~fault_q;
`else
  assign run_ok = 1'b1;
`endif

  assign tick = Enable && (cnt_q == PER_MAX);

  always_comb begin
    cnt_d = '0;
    if (Enable && (cnt_q != PER_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  // Ticks that land while a sequence is in flight are dropped and counted.
  always_comb begin
    ovr_d = ovr_q;
    if (tick && run_ok && (state_q != IDLE) && (ovr_q != 8'hFF))
      ovr_d = ovr_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wd_q         <= '0;
      ovr_q        <= '0;
      adc_start_q  <= 1'b0;
      y_load_q     <= 1'b0;
      calc_start_q <= 1'b0;
      u_load_q     <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      ovr_q        <= ovr_d;
      adc_start_q  <= 1'b0;
      y_load_q     <= 1'b0;
      calc_start_q <= 1'b0;
      u_load_q     <= 1'b0;
      wd_q         <= wd_q + 1'b1;
      fault_q      <= fault_q & ~fault_clr;
      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (tick && run_ok) begin
            state_q     <= ADC_WAIT;
            adc_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ADC_WAIT: begin
          if (adc_done) begin
            state_q  <= LOAD;
            y_load_q <= 1'b1;
            wd_q     <= '0;
          end else if (wd_q == ADC_MAX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            wd_q    <= '0;
          end
        end
        LOAD: begin
          state_q      <= CALC;
          calc_start_q <= 1'b1;
          wd_q         <= '0;
        end
        CALC: begin
          // wd_q == 0 marks the calc_start cycle, where calc_done is stale.
          if ((wd_q != '0) && calc_done) begin
            state_q  <= UPDATE;
            u_load_q <= 1'b1;
            wd_q     <= '0;
          end else if (wd_q == CALC_MAX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            wd_q    <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          wd_q    <= '0;
        end
      endcase
    end
  end

  assign adc_start   = adc_start_q;
  assign y_load      = y_load_q;
  assign calc_start  = calc_start_q;
  assign u_load      = u_load_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign overrun_cnt = ovr_q;
  assign state       = state_q;

endmodule

// File: tb/tb_control_loop_sequencer.sv
// Scoreboard bench for control_loop_sequencer (PERIOD=20, timeouts 10/6).
// A second instance with ADC_TIMEOUT=40 exercises overrun saturation.
module tb_control_loop_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       Reset = 1'b0, Enable = 1'b0, fault_clr = 1'b0;
  logic       adc_done = 1'b0, calc_done = 1'b0;
  logic       adc_start, y_load, calc_start, u_load, busy, fault;
  logic [7:0] overrun_cnt;
  logic [2:0] state;

  logic       rst2 = 1'b0, en2 = 1'b0, fault_clr2 = 1'b0;
  logic       adc_done2 = 1'b0, calc_done2 = 1'b0;
  logic       adc_start2, y_load2, calc_start2, u_load2, busy2, fault2;
  logic [7:0] overrun_cnt2;
  logic [2:0] state2;

  control_loop_sequencer #(
    .PERIOD(20), .ADC_TIMEOUT(10), .CALC_TIMEOUT(6), .CNT_W(20)
  ) dut (
    .CLK(CLK), .Reset(Reset), .Enable(Enable), .fault_clr(fault_clr),
    .adc_start(adc_start), .adc_done(adc_done), .y_load(y_load),
    .calc_start(calc_start), .calc_done(calc_done), .u_load(u_load),
    .busy(busy), .fault(fault), .overrun_cnt(overrun_cnt), .state(state)
  );

  control_loop_sequencer #(
    .PERIOD(20), .ADC_TIMEOUT(40), .CALC_TIMEOUT(6), .CNT_W(20)
  ) dut2 (
    .CLK(CLK), .Reset(rst2), .Enable(en2), .fault_clr(fault_clr2),
    .adc_start(adc_start2), .adc_done(adc_done2), .y_load(y_load2),
    .calc_start(calc_start2), .calc_done(calc_done2), .u_load(u_load2),
    .busy(busy2), .fault(fault2), .overrun_cnt(overrun_cnt2),
    .state(state2)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int R = 0;
  int s0;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;
  exp_t sb[$];

  // kinds: 0 adc_start, 1 y_load, 2 calc_start, 3 u_load, 4 fault rise
  logic       fault_prev = 1'b0;
  logic [4:0] ev;
  assign ev = {fault & ~fault_prev, u_load, calc_start, y_load, adc_start};

  always @(negedge CLK) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_missing: got no event, expected kind %0d at cycle %0d",
               sb[0].kind, sb[0].cyc);
      sb.delete(0);
    end
    for (int k = 0; k < 5; k++) begin
      if (ev[k] === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got kind %0d at cycle %0d, expected none",
                   k, cyc);
        end else begin
          e = sb[0];
          sb.delete(0);
          if (e.kind != k || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL sb_event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                     k, cyc, e.kind, e.cyc);
          end
        end
      end
    end
    fault_prev <= fault;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = R + c;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    wait_to(c);
    @(negedge CLK);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got no finish, expected end of test");
    $fatal(1, "time limit");
  end

  initial begin
    int B;
    int T;
    int e_ovr;
    Enable = 1'b1;
    // reset state
    at_neg(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_adc_start", 32'(adc_start), 0);
    chk("rst_y_load", 32'(y_load), 0);
    chk("rst_calc_start", 32'(calc_start), 0);
    chk("rst_u_load", 32'(u_load), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_ovr", 32'(overrun_cnt), 0);
    wait_to(5);
    Reset = 1'b1;
    R = 5;

    // nominal sequence
    push(0, 20); push(1, 24); push(2, 25); push(3, 28);
    at_neg(R + 21);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_state_adc", 32'(state), 1);
    wait_to(R + 23); adc_done = 1'b1;
    wait_to(R + 24); adc_done = 1'b0;
    at_neg(R + 26);
    chk("t1_state_calc", 32'(state), 3);
    wait_to(R + 27); calc_done = 1'b1;
    wait_to(R + 28); calc_done = 1'b0;
    at_neg(R + 29);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_state", 32'(state), 0);
    chk("t1_ovr", 32'(overrun_cnt), 0);

    // ADC timeout
    push(0, 40); push(4, 50);
    at_neg(R + 49);
    chk("t2_fault_pre", 32'(fault), 0);
    chk("t2_state_pre", 32'(state), 1);
    at_neg(R + 50);
    chk("t2_fault", 32'(fault), 1);
    chk("t2_state", 32'(state), 0);

    // calc_done stuck high
    wait_to(R + 55); calc_done = 1'b1;
`ifdef LOOP_SEQ_HOLD_ON_FAULT_EN
    s0 = 80;
`else
    s0 = 60;
`endif
    push(0, s0); push(1, s0 + 2); push(2, s0 + 3); push(3, s0 + 5);
    push(0, s0 + 20); push(1, s0 + 22); push(2, s0 + 23); push(3, s0 + 25);
`ifdef LOOP_SEQ_HOLD_ON_FAULT_EN
    at_neg(R + 66);
    chk("t2_hold_fault", 32'(fault), 1);
    chk("t2_hold_state", 32'(state), 0);
    fault_clr = 1'b1;
    wait_to(R + 67); fault_clr = 1'b0;
`endif
    wait_to(R + s0 + 1); adc_done = 1'b1;
    wait_to(R + s0 + 2); adc_done = 1'b0;
    at_neg(R + s0 + 4);
    chk("t3_calc_hold", 32'(state), 3);
    wait_to(R + s0 + 21); adc_done = 1'b1;
    wait_to(R + s0 + 22); adc_done = 1'b0;
    at_neg(R + s0 + 26);
`ifndef LOOP_SEQ_HOLD_ON_FAULT_EN
    chk("t3_fault_sticky", 32'(fault), 1);
    fault_clr = 1'b1;
`endif
    calc_done = 1'b0;
    wait_to(R + s0 + 27); fault_clr = 1'b0;
    at_neg(R + s0 + 27);
    chk("t3_fault_clr", 32'(fault), 0);
    chk("t3_state", 32'(state), 0);

    // CALC timeout with fault_clr in the same cycle as the new fault
    push(0, s0 + 40); push(1, s0 + 42); push(2, s0 + 43); push(4, s0 + 49);
    wait_to(R + s0 + 41); adc_done = 1'b1;
    wait_to(R + s0 + 42); adc_done = 1'b0;
    at_neg(R + s0 + 48);
    chk("calc_to_state", 32'(state), 3);
    chk("calc_to_fault_pre", 32'(fault), 0);
    fault_clr = 1'b1;
    at_neg(R + s0 + 49);
    chk("calc_to_fault_wins", 32'(fault), 1);
    chk("calc_to_idle", 32'(state), 0);
    wait_to(R + s0 + 50); fault_clr = 1'b0;
    at_neg(R + s0 + 50);
    chk("calc_to_cleared", 32'(fault), 0);

    // reset during CALC
    push(0, s0 + 60); push(1, s0 + 62);
    wait_to(R + s0 + 61); adc_done = 1'b1;
    wait_to(R + s0 + 62); adc_done = 1'b0;
    wait_to(R + s0 + 63);
    Reset = 1'b0;
    calc_done = 1'b1;
    at_neg(R + s0 + 63);
    chk("t5_state", 32'(state), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_calc_start", 32'(calc_start), 0);
    chk("t5_u_load", 32'(u_load), 0);
    wait_to(R + s0 + 66);
    Reset = 1'b1;
    R = R + s0 + 66;
    at_neg(R + 1);
    chk("t5_rel_state", 32'(state), 0);
    chk("t5_rel_ovr", 32'(overrun_cnt), 0);
    wait_to(R + 4); calc_done = 1'b0;

    // Enable dropped mid-sequence
    push(0, 20); push(1, 24); push(2, 25); push(3, 28);
    wait_to(R + 21); Enable = 1'b0;
    wait_to(R + 23); adc_done = 1'b1;
    wait_to(R + 24); adc_done = 1'b0;
    wait_to(R + 27); calc_done = 1'b1;
    wait_to(R + 28); calc_done = 1'b0;
    at_neg(R + 29);
    chk("t6_state", 32'(state), 0);
    chk("t6_busy", 32'(busy), 0);
    push(0, 80); push(1, 82); push(2, 83); push(3, 85);
    wait_to(R + 60); Enable = 1'b1;
    wait_to(R + 81); adc_done = 1'b1;
    wait_to(R + 82); adc_done = 1'b0;
    wait_to(R + 84); calc_done = 1'b1;
    wait_to(R + 85); calc_done = 1'b0;
    at_neg(R + 86);
    chk("t6_end_state", 32'(state), 0);
    chk("t6_ovr", 32'(overrun_cnt), 0);
    Enable = 1'b0;

    // overrun counting and saturation on the long-ADC instance
    wait_to(cyc + 2);
    rst2 = 1'b1;
    en2 = 1'b1;
    calc_done2 = 1'b1;
    B = cyc;
    for (int k = 0; k < 300; k++) begin
      T = B + 20 + 40 * k;
      wait_to(T + 25); adc_done2 = 1'b1;
      wait_to(T + 26); adc_done2 = 1'b0;
      if (k == 0 || k == 1 || k == 99 || k == 253 || k == 254 || k == 299) begin
        at_neg(T + 26);
        e_ovr = (k + 1 > 255) ? 255 : k + 1;
        chk("t4_ovr", 32'(overrun_cnt2), 32'(e_ovr));
      end
    end
    at_neg(cyc + 2);
    chk("t4_fault", 32'(fault2), 0);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
